// File: rtl/pattern_detector.sv
// ---------------------------------------------------------------------------
// pattern_detector
//   Serial bit-pattern detector. Bits arrive on A (sampled when en=1), are
//   shifted into a history register (newest bit in LSB) and compared against
//   a loadable pattern register (MSB = first bit received). A match produces
//   a one-cycle registered pulse on Y and bumps a saturating match counter.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   en         in   1      sample enable for A
//   A          in   1      serial input bit
//   pat_load   in   1      load pat_in into the pattern register (priority over en)
//   pat_in     in   PAT_W  new pattern, MSB first-received
//   Y          out  1      registered match pulse, one cycle after the final bit
//   match_cnt  out  CNT_W  matches since reset/load, saturating at all-ones
//   cnt_sat    out  1      high while match_cnt is all-ones
// ---------------------------------------------------------------------------
module pattern_detector #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(5'b11010),
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             A,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   output logic             Y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PAT_W);

   // FILL: fewer than PAT_W valid history bits; ARMED: history fully valid.
   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;

   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [PAT_W-1:0] hist_q,    hist_d;
   logic [FW-1:0]    fill_q,    fill_d;
   logic [0:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             y_q,       y_d;
   logic             sat_q,     sat_d;

   logic [PAT_W-1:0] hist_shift;
   logic [FW-1:0]    fill_inc;
   logic             hit;

   // Candidate history/fill if the current bit were consumed.
   assign hist_shift = {hist_q[PAT_W-2:0], A};
   assign fill_inc   = (state_q == ST_ARMED) ? fill_q : fill_q + FW'(1);
   assign hit        = (hist_shift == pattern_q) && (fill_inc == FULL);

   always_comb begin
      pattern_d = pattern_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      y_d       = 1'b0;

      if (pat_load) begin
         // A is discarded on a load edge, even with en=1.
         pattern_d = pat_in;
         hist_d    = '0;
         fill_d    = '0;
         cnt_d     = '0;
      end else if (en) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         if (hit) begin
            y_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}})
               cnt_d = cnt_q + CNT_W'(1);
            // Non-overlapping mode: the next match needs PAT_W fresh bits.
            if (!OVERLAP)
               fill_d = '0;
         end
      end

      state_d = (fill_d == FULL) ? ST_ARMED : ST_FILL;
      sat_d   = &cnt_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= PATTERN;
         hist_q    <= '0;
         fill_q    <= '0;
         state_q   <= ST_FILL;
         cnt_q     <= '0;
         y_q       <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         sat_q     <= sat_d;
      end
   end

   assign Y         = y_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector
//   Three detector instances: 0 = defaults, 1 = OVERLAP=0, 2 = CNT_W=2.
//   Each stimulus step drives one instance (others idle with en=0) and pushes
//   the hand-computed expected outputs for the following cycle into a queue;
//   a separate monitor pops and compares once the result is due.
// ---------------------------------------------------------------------------
module tb_pattern_detector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]      rst_v, en_v, a_v, ld_v;
   logic [2:0][4:0] pat_v;
   logic [2:0]      y_w, sat_w;
   logic [7:0]      cnt0_w, cnt1_w;
   logic [1:0]      cnt2_w;

   pattern_detector u_dut0 (
      .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .A(a_v[0]),
      .pat_load(ld_v[0]), .pat_in(pat_v[0]),
      .Y(y_w[0]), .match_cnt(cnt0_w), .cnt_sat(sat_w[0]));

   pattern_detector #(.OVERLAP(1'b0)) u_dut1 (
      .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .A(a_v[1]),
      .pat_load(ld_v[1]), .pat_in(pat_v[1]),
      .Y(y_w[1]), .match_cnt(cnt1_w), .cnt_sat(sat_w[1]));

   pattern_detector #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .A(a_v[2]),
      .pat_load(ld_v[2]), .pat_in(pat_v[2]),
      .Y(y_w[2]), .match_cnt(cnt2_w), .cnt_sat(sat_w[2]));

   typedef struct {
      int         d;
      int         due;
      logic       y;
      logic [7:0] cnt;
      logic       sat;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // One stimulus edge for instance d, with the outputs expected after it.
   task automatic step(input int d, input bit r, input bit e, input bit a,
                       input bit l, input logic [4:0] p,
                       input bit ey, input int ec, input bit es, input string tag);
      exp_t x;
      @(posedge clk);
      #1;
      rst_v = '0; en_v = '0; ld_v = '0; a_v = '0;
      rst_v[d] = r; en_v[d] = e; a_v[d] = a; ld_v[d] = l; pat_v[d] = p;
      x.d = d; x.due = cyc + 1; x.y = ey; x.cnt = 8'(ec); x.sat = es; x.tag = tag;
      sb.push_back(x);
   endtask

   // Monitor: compares the queue head once its result cycle has arrived.
   initial begin
      exp_t       x;
      logic       gy, gs;
      logic [7:0] gc;
      forever begin
         @(posedge clk);
         #3;
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            case (x.d)
               0:       begin gy = y_w[0]; gc = cnt0_w;         gs = sat_w[0]; end
               1:       begin gy = y_w[1]; gc = cnt1_w;         gs = sat_w[1]; end
               default: begin gy = y_w[2]; gc = {6'd0, cnt2_w}; gs = sat_w[2]; end
            endcase
            n_vec++;
            if (gy !== x.y || gc !== x.cnt || gs !== x.sat) begin
               n_err++;
               $display("FAIL %s: got Y=%0b cnt=%0d sat=%0b, expected Y=%0b cnt=%0d sat=%0b",
                        x.tag, gy, gc, gs, x.y, x.cnt, x.sat);
            end else begin
               $display("ok   %s: Y=%0b cnt=%0d sat=%0b", x.tag, gy, gc, gs);
            end
         end
      end
   end

   logic [4:0] pv;
   int cb[4] = '{0, 1, 2, 3};
   int ca[4] = '{1, 2, 3, 3};
   bit sb4[4] = '{0, 0, 0, 1};
   bit sa4[4] = '{0, 0, 1, 1};

   initial begin
      rst_v = 3'b111; en_v = '0; a_v = '0; ld_v = '0; pat_v = '0;
      repeat (2) @(posedge clk);

      // Instance 0, default pattern 11010, overlapping
      step(0,1,0,0,0,5'd0, 0,0,0, "reset_state");
      step(0,0,1,1,0,5'd0, 0,0,0, "basic_b1");
      step(0,0,1,1,0,5'd0, 0,0,0, "basic_b2");
      step(0,0,1,0,0,5'd0, 0,0,0, "basic_b3");
      step(0,0,1,1,0,5'd0, 0,0,0, "basic_b4");
      step(0,0,1,0,0,5'd0, 1,1,0, "basic_b5_match");
      step(0,0,0,0,0,5'd0, 0,1,0, "basic_after");

      // Reset mid-sequence discards partial history
      step(0,1,0,0,0,5'd0, 0,0,0, "rst_clear");
      step(0,0,1,1,0,5'd0, 0,0,0, "rstmid_b1");
      step(0,0,1,1,0,5'd0, 0,0,0, "rstmid_b2");
      step(0,0,1,0,0,5'd0, 0,0,0, "rstmid_b3");
      step(0,1,1,1,0,5'd0, 0,0,0, "rstmid_reset");
      step(0,0,1,1,0,5'd0, 0,0,0, "rstmid_b4");
      step(0,0,1,0,0,5'd0, 0,0,0, "rstmid_b5");

      // en=0 holds state across a gap
      step(0,1,0,0,0,5'd0, 0,0,0, "en_rst");
      step(0,0,1,1,0,5'd0, 0,0,0, "en_b1");
      step(0,0,1,1,0,5'd0, 0,0,0, "en_b2");
      step(0,0,0,0,0,5'd0, 0,0,0, "en_gap1");
      step(0,0,0,0,0,5'd0, 0,0,0, "en_gap2");
      step(0,0,0,0,0,5'd0, 0,0,0, "en_gap3");
      step(0,0,1,0,0,5'd0, 0,0,0, "en_b3");
      step(0,0,1,1,0,5'd0, 0,0,0, "en_b4");
      step(0,0,1,0,0,5'd0, 1,1,0, "en_b5_match");
      step(0,0,0,0,0,5'd0, 0,1,0, "en_after");

      // pat_load wins over en; final bit discarded, counter cleared
      step(0,0,1,1,0,5'd0, 0,1,0, "ld_b1");
      step(0,0,1,1,0,5'd0, 0,1,0, "ld_b2");
      step(0,0,1,0,0,5'd0, 0,1,0, "ld_b3");
      step(0,0,1,1,0,5'd0, 0,1,0, "ld_b4");
      step(0,0,1,0,1,5'b11010, 0,0,0, "ld_prio");
      step(0,0,1,1,0,5'd0, 0,0,0, "ld_f1");
      step(0,0,1,1,0,5'd0, 0,0,0, "ld_f2");
      step(0,0,1,0,0,5'd0, 0,0,0, "ld_f3");
      step(0,0,1,1,0,5'd0, 0,0,0, "ld_f4");
      step(0,0,1,0,0,5'd0, 1,1,0, "ld_f5_match");

      // Overlapping matches on loaded pattern 10101
      step(0,0,0,0,1,5'b10101, 0,0,0, "ov_load");
      step(0,0,1,1,0,5'd0, 0,0,0, "ov_b1");
      step(0,0,1,0,0,5'd0, 0,0,0, "ov_b2");
      step(0,0,1,1,0,5'd0, 0,0,0, "ov_b3");
      step(0,0,1,0,0,5'd0, 0,0,0, "ov_b4");
      step(0,0,1,1,0,5'd0, 1,1,0, "ov_b5_match");
      step(0,0,1,0,0,5'd0, 0,1,0, "ov_b6");
      step(0,0,1,1,0,5'd0, 1,2,0, "ov_b7_match");
      step(0,0,0,0,0,5'd0, 0,2,0, "ov_after");

      // Instance 1, non-overlapping, same stream
      step(1,1,0,0,0,5'd0, 0,0,0, "nov_rst");
      step(1,0,0,0,1,5'b10101, 0,0,0, "nov_load");
      step(1,0,1,1,0,5'd0, 0,0,0, "nov_b1");
      step(1,0,1,0,0,5'd0, 0,0,0, "nov_b2");
      step(1,0,1,1,0,5'd0, 0,0,0, "nov_b3");
      step(1,0,1,0,0,5'd0, 0,0,0, "nov_b4");
      step(1,0,1,1,0,5'd0, 1,1,0, "nov_b5_match");
      step(1,0,1,0,0,5'd0, 0,1,0, "nov_b6");
      step(1,0,1,1,0,5'd0, 0,1,0, "nov_b7_nomatch");
      step(1,0,1,0,0,5'd0, 0,1,0, "nov_b8");
      step(1,0,1,1,0,5'd0, 0,1,0, "nov_b9");
      step(1,0,1,0,0,5'd0, 0,1,0, "nov_b10");
      step(1,0,1,1,0,5'd0, 1,2,0, "nov_b11_match");

      // Instance 2, 2-bit counter saturation
      step(2,1,0,0,0,5'd0, 0,0,0, "sat_rst");
      pv = 5'b11010;
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 5; b++) begin
            if (b < 4)
               step(2,0,1,pv[4-b],0,5'd0, 0,cb[k],sb4[k], $sformatf("sat_g%0d_b%0d", k, b));
            else
               step(2,0,1,pv[4-b],0,5'd0, 1,ca[k],sa4[k], $sformatf("sat_g%0d_match", k));
         end
      end
      step(2,0,0,0,0,5'd0, 0,3,1, "sat_hold");
      step(2,1,0,0,0,5'd0, 0,0,0, "sat_rst_clear");

      // Drain the scoreboard, bounded
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #5;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
